// File: rtl/vga_rect_ctrl.sv
// Shadow-register controller for the VGA rectangle renderer: CPU writes land in shadows,
// and a commit or animation step updates the active edges only at the edge that samples a VGA_VS fall.
module vga_rect_ctrl #(
  parameter int H_MAX  = 639,
  parameter int V_MAX  = 479,
  parameter int X1_RST = 270,
  parameter int X2_RST = 370,
  parameter int Y1_RST = 190,
  parameter int Y2_RST = 290
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        wr_req,
  input  logic [2:0]  wr_addr,
  input  logic [10:0] wr_data,
  input  logic        VGA_VS,
  output logic [10:0] x1,
  output logic [10:0] x2,
  output logic [10:0] y1,
  output logic [10:0] y2,
  output logic        wr_ack,
  output logic        busy,
  output logic        err,
  output logic [15:0] frame_count
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam logic [10:0] HLIM = 11'(H_MAX);
  localparam logic [10:0] VLIM = 11'(V_MAX);
  localparam logic [10:0] X1R  = 11'(X1_RST);
  localparam logic [10:0] X2R  = 11'(X2_RST);
  localparam logic [10:0] Y1R  = 11'(Y1_RST);
  localparam logic [10:0] Y2R  = 11'(Y2_RST);

  logic [10:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic [10:0] sx1_q, sx1_d, sx2_q, sx2_d, sy1_q, sy1_d, sy2_q, sy2_d;
  logic        anim_en_q, anim_en_d;
  logic [3:0]  step_q, step_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        wr_ack_q, wr_ack_d;
  logic        err_q, err_d;
  logic [15:0] fc_q, fc_d;
  logic        vs_prev_q, vs_prev_d;
  logic [0:0]  state_q, state_d;

  logic        fe;
  logic        accept;
  logic        commit_acc;
  logic        shadow_ok;
  logic [22:0] ax, ay;

  // One bounce step on one axis; result is {dir, lo, hi}, dir=1 means moving toward 0.
  function automatic logic [22:0] step_axis(input logic [10:0] lo, input logic [10:0] hi,
                                            input logic dir, input logic [3:0] stp,
                                            input logic [10:0] lim);
    logic [10:0] w;
    logic [22:0] r;
    w = hi - lo;
    if (!dir) begin
      if (({1'b0, hi} + {8'd0, stp}) > {1'b0, lim}) r = {1'b1, lim - w, lim};
      else                                          r = {1'b0, lo + {7'd0, stp}, hi + {7'd0, stp}};
    end else begin
      if ({1'b0, lo} < {8'd0, stp}) r = {1'b0, 11'd0, w};
      else                          r = {1'b1, lo - {7'd0, stp}, hi - {7'd0, stp}};
    end
    return r;
  endfunction

  always_comb begin
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    sx1_d     = sx1_q;
    sx2_d     = sx2_q;
    sy1_d     = sy1_q;
    sy2_d     = sy2_q;
    anim_en_d = anim_en_q;
    step_d    = step_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    err_d     = err_q;
    state_d   = state_q;
    vs_prev_d = VGA_VS;

    fe         = vs_prev_q & ~VGA_VS;
    fc_d       = fe ? fc_q + 16'd1 : fc_q;
    accept     = (state_q == IDLE) && wr_req && !wr_ack_q;
    commit_acc = accept && (wr_addr == 3'd5);
    wr_ack_d   = accept;
    shadow_ok  = (sx1_q < sx2_q) && (sy1_q < sy2_q) && (sx2_q <= HLIM) && (sy2_q <= VLIM);
    ax         = step_axis(x1_q, x2_q, dir_x_q, step_q, HLIM);
    ay         = step_axis(y1_q, y2_q, dir_y_q, step_q, VLIM);

    if (accept) begin
      case (wr_addr)
        3'd0: begin sx1_d = wr_data; err_d = 1'b0; end
        3'd1: begin sx2_d = wr_data; err_d = 1'b0; end
        3'd2: begin sy1_d = wr_data; err_d = 1'b0; end
        3'd3: begin sy2_d = wr_data; err_d = 1'b0; end
        3'd4: begin
          anim_en_d = wr_data[0];
          step_d    = wr_data[4:1];
          err_d     = 1'b0;
        end
        3'd5:    state_d = PENDING;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        // A commit accepted on a frame edge suppresses animation; it lands next frame.
        if (!commit_acc && fe && anim_en_q) begin
          {dir_x_d, x1_d, x2_d} = ax;
          {dir_y_d, y1_d, y2_d} = ay;
        end
      end
      default: begin
        if (fe) begin
          if (shadow_ok) begin
            x1_d = sx1_q;
            x2_d = sx2_q;
            y1_d = sy1_q;
            y2_d = sy2_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      x1_q      <= X1R;
      x2_q      <= X2R;
      y1_q      <= Y1R;
      y2_q      <= Y2R;
      sx1_q     <= X1R;
      sx2_q     <= X2R;
      sy1_q     <= Y1R;
      sy2_q     <= Y2R;
      anim_en_q <= 1'b0;
      step_q    <= 4'd1;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      fc_q      <= 16'd0;
      vs_prev_q <= 1'b1;
      state_q   <= IDLE;
    end else begin
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      sx1_q     <= sx1_d;
      sx2_q     <= sx2_d;
      sy1_q     <= sy1_d;
      sy2_q     <= sy2_d;
      anim_en_q <= anim_en_d;
      step_q    <= step_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      wr_ack_q  <= wr_ack_d;
      err_q     <= err_d;
      fc_q      <= fc_d;
      vs_prev_q <= vs_prev_d;
      state_q   <= state_d;
    end
  end

  assign x1          = x1_q;
  assign x2          = x2_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign wr_ack      = wr_ack_q;
  assign busy        = (state_q == PENDING);
  assign err         = err_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_rect_ctrl.sv
// Directed bench for vga_rect_ctrl: expected rectangles are queued when a commit or
// animation frame is set up and popped at the frame edge that must apply them.
module tb_vga_rect_ctrl;

  typedef struct packed {
    logic [10:0] x1;
    logic [10:0] x2;
    logic [10:0] y1;
    logic [10:0] y2;
  } rect_t;

  logic        CLOCK_50;
  logic        Reset;
  logic        wr_req;
  logic [2:0]  wr_addr;
  logic [10:0] wr_data;
  logic        VGA_VS;
  logic [10:0] x1, x2, y1, y2;
  logic        wr_ack, busy, err;
  logic [15:0] frame_count;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_fc   = 0;
  int    adj_err  = 0;
  logic  ack_prev = 1'b0;
  rect_t exp_q[$];

  vga_rect_ctrl dut (
    .CLOCK_50    (CLOCK_50),
    .Reset       (Reset),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .VGA_VS      (VGA_VS),
    .x1          (x1),
    .x2          (x2),
    .y1          (y1),
    .y2          (y2),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .err         (err),
    .frame_count (frame_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (wr_ack && ack_prev) adj_err++;
    ack_prev = wr_ack;
  end

  initial begin
    #6000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic rect_t mk(input int a, input int b, input int c, input int d);
    rect_t r;
    r.x1 = 11'(a);
    r.x2 = 11'(b);
    r.y1 = 11'(c);
    r.y2 = 11'(d);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_rect(input string tag);
    rect_t r;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk({tag, "_x1"}, x1, r.x1);
      chk({tag, "_x2"}, x2, r.x2);
      chk({tag, "_y1"}, y1, r.y1);
      chk({tag, "_y2"}, y2, r.y2);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [10:0] d);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    do begin
      @(posedge CLOCK_50);
      #1;
      n++;
    end while (!wr_ack && n < 50);
    chk("wr_ack_seen", wr_ack, 1);
    wr_req = 1'b0;
  endtask

  task automatic frame(input string tag);
    @(negedge CLOCK_50);
    VGA_VS = 1'b0;
    @(posedge CLOCK_50);
    #1;
    exp_fc++;
    cmp_rect(tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fc"}, frame_count, 32'(exp_fc[15:0]));
    @(negedge CLOCK_50);
    VGA_VS = 1'b1;
  endtask

  initial begin
    int acks;
    Reset   = 1'b1;
    VGA_VS  = 1'b1;
    wr_req  = 1'b0;
    wr_addr = 3'd0;
    wr_data = 11'd0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    Reset = 1'b0;
    chk("rst_x1", x1, 270);
    chk("rst_x2", x2, 370);
    chk("rst_y1", y1, 190);
    chk("rst_y2", y2, 290);
    chk("rst_ack", wr_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_fc", frame_count, 0);

    // Valid commit: active edges wait for the frame edge.
    wr(3'd0, 11'd100);
    wr(3'd1, 11'd200);
    wr(3'd2, 11'd50);
    wr(3'd3, 11'd150);
    wr(3'd5, 11'd0);
    exp_q.push_back(mk(100, 200, 50, 150));
    chk("commit_busy", busy, 1);
    repeat (4) @(posedge CLOCK_50);
    #1;
    chk("commit_hold_x1", x1, 270);
    chk("commit_hold_y2", y2, 290);
    frame("commit");

    // Invalid commit (x1 > x2) leaves the active rectangle alone and sets err.
    wr(3'd0, 11'd300);
    wr(3'd5, 11'd0);
    exp_q.push_back(mk(100, 200, 50, 150));
    frame("bad_commit");
    chk("bad_commit_err", err, 1);
    wr(3'd0, 11'd100);
    chk("err_cleared", err, 0);

    // Animation bounce at the right edge with step 4.
    wr(3'd0, 11'd600);
    wr(3'd1, 11'd636);
    wr(3'd5, 11'd0);
    exp_q.push_back(mk(600, 636, 50, 150));
    frame("anim_setup");
    wr(3'd4, 11'd9);
    exp_q.push_back(mk(603, 639, 54, 154));
    frame("anim1");
    exp_q.push_back(mk(599, 635, 58, 158));
    frame("anim2");
    wr(3'd4, 11'd8);
    exp_q.push_back(mk(599, 635, 58, 158));
    frame("anim_off");

    // Write held off while a commit is pending.
    wr(3'd5, 11'd0);
    exp_q.push_back(mk(600, 636, 50, 150));
    @(negedge CLOCK_50);
    wr_req  = 1'b1;
    wr_addr = 3'd0;
    wr_data = 11'd10;
    acks = 0;
    repeat (6) begin
      @(posedge CLOCK_50);
      #1;
      if (wr_ack) acks++;
    end
    chk("stall_no_ack", acks, 0);
    chk("stall_busy", busy, 1);
    @(negedge CLOCK_50);
    VGA_VS = 1'b0;
    @(posedge CLOCK_50);
    #1;
    exp_fc++;
    chk("stall_ack_at_fe", wr_ack, 0);
    chk("stall_busy_drop", busy, 0);
    cmp_rect("stall_commit");
    @(posedge CLOCK_50);
    #1;
    chk("stall_ack_after_idle", wr_ack, 1);
    wr_req = 1'b0;
    @(negedge CLOCK_50);
    VGA_VS = 1'b1;

    // Commit accepted on the same edge as a frame event lands on the following frame.
    @(negedge CLOCK_50);
    wr_req  = 1'b1;
    wr_addr = 3'd5;
    VGA_VS  = 1'b0;
    @(posedge CLOCK_50);
    #1;
    exp_fc++;
    chk("sim_ack", wr_ack, 1);
    chk("sim_busy", busy, 1);
    chk("sim_x1_unchanged", x1, 600);
    chk("sim_fc", frame_count, 32'(exp_fc[15:0]));
    wr_req = 1'b0;
    exp_q.push_back(mk(10, 636, 50, 150));
    @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    frame("sim_commit");

    // Frame counter wrap.
    do begin
      @(negedge CLOCK_50);
      VGA_VS = 1'b0;
      @(negedge CLOCK_50);
      VGA_VS = 1'b1;
      exp_fc++;
    end while ((exp_fc % 65536) != 0);
    @(posedge CLOCK_50);
    #1;
    chk("fc_wrap", frame_count, 0);

    // Reset while a commit is pending abandons it.
    wr(3'd0, 11'd20);
    wr(3'd5, 11'd0);
    chk("pre_rst_busy", busy, 1);
    @(negedge CLOCK_50);
    Reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_x1", x1, 270);
    chk("midrst_x2", x2, 370);
    chk("midrst_y1", y1, 190);
    chk("midrst_y2", y2, 290);
    chk("midrst_fc", frame_count, 0);
    @(negedge CLOCK_50);
    Reset  = 1'b0;
    exp_fc = 0;
    exp_q.push_back(mk(270, 370, 190, 290));
    frame("post_rst");

    chk("ack_never_adjacent", adj_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
